// File: rtl/vram_readback_checker_pkg.sv
// vram_readback_checker_pkg: shared widths, FSM encodings and pipeline stage records for the VRAM readback checker
package vram_readback_checker_pkg;
  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 8;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;
  typedef struct packed {
    logic                   v;
    logic                   pd;
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] exp_a;
    logic [VRAM_DATA_W-1:0] exp_b;
    logic [VRAM_DATA_W-1:0] got_a;
    logic [VRAM_DATA_W-1:0] got_b;
  } s1_t;
  typedef struct packed {
    logic                     v;
    logic                     pd;
    logic                     mis_a;
    logic                     mis_b;
    logic [VRAM_ADDR_W-1:0]   addr;
    logic [2*VRAM_DATA_W-1:0] got;
  } s2_t;
endpackage

// File: rtl/vram_readback_checker_if.sv
// vram_readback_checker_if: sample/pass inputs and status outputs of the readback checker
//   master drives clear, sample_valid, sample_addr, exp_a/b, got_a/b, pass_done
//   slave drives err_count, first_err_*, pass_count, pass_report, last_pass_ok, led_ok, led_fail, state
interface vram_readback_checker_if #(
  parameter int ERR_W  = 16,
  parameter int PASS_W = 8
);
  logic                                               clear;
  logic                                               sample_valid;
  logic [vram_readback_checker_pkg::VRAM_ADDR_W-1:0]  sample_addr;
  logic [vram_readback_checker_pkg::VRAM_DATA_W-1:0]  exp_a;
  logic [vram_readback_checker_pkg::VRAM_DATA_W-1:0]  exp_b;
  logic [vram_readback_checker_pkg::VRAM_DATA_W-1:0]  got_a;
  logic [vram_readback_checker_pkg::VRAM_DATA_W-1:0]  got_b;
  logic                                               pass_done;
  logic [ERR_W-1:0]                                   err_count;
  logic                                               first_err_valid;
  logic [vram_readback_checker_pkg::VRAM_ADDR_W-1:0]  first_err_addr;
  logic [1:0]                                         first_err_chip;
  logic [2*vram_readback_checker_pkg::VRAM_DATA_W-1:0] first_err_got;
  logic [PASS_W-1:0]                                  pass_count;
  logic                                               pass_report;
  logic                                               last_pass_ok;
  logic                                               led_ok;
  logic                                               led_fail;
  logic [1:0]                                         state;
  modport master (
    output clear, sample_valid, sample_addr, exp_a, exp_b, got_a, got_b, pass_done,
    input  err_count, first_err_valid, first_err_addr, first_err_chip, first_err_got,
           pass_count, pass_report, last_pass_ok, led_ok, led_fail, state
  );
  modport slave (
    input  clear, sample_valid, sample_addr, exp_a, exp_b, got_a, got_b, pass_done,
    output err_count, first_err_valid, first_err_addr, first_err_chip, first_err_got,
           pass_count, pass_report, last_pass_ok, led_ok, led_fail, state
  );
endinterface

// File: rtl/vram_readback_checker_pulse_stretch.sv
// pulse_stretch: retriggerable stretcher, out_o high for CLOCKS cycles after the last trig_i
//   clk_i, rst_i (sync, active-high), trig_i reloads the down-counter, out_o = counter nonzero
module pulse_stretch #(
  parameter int CLOCKS = 12000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic trig_i,
  output logic out_o
);
  localparam int W = $clog2(CLOCKS + 1);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk_i)
    cnt_q <= rst_i ? '0 : trig_i ? W'(CLOCKS) : cnt_q - W'(cnt_q != '0);
  assign out_o = cnt_q != '0;
endmodule

// File: rtl/vram_readback_checker.sv
// vram_readback_checker: compares VRAM chip A/B readback against expected bytes, keeps error/pass stats and LED status
//   clk_i, rst_i (sync, active-high); bus (slave modport) carries samples, pass_done, clear and all status outputs
module vram_readback_checker
  import vram_readback_checker_pkg::*;
#(
  parameter int ERR_W   = 16,
  parameter int PASS_W  = 8,
  parameter int STRETCH = 12000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  vram_readback_checker_if.slave   bus
);
  logic                     srst;
  s1_t                      s1_q, s1_d;
  s2_t                      s2_q, s2_d;
  logic                     mis, cap;
  logic [ERR_W-1:0]         err_q, err_d;
  logic                     fv_q, fv_d;
  logic [VRAM_ADDR_W-1:0]   fa_q, fa_d;
  logic [1:0]               fc_q, fc_d;
  logic [2*VRAM_DATA_W-1:0] fg_q, fg_d;
  logic                     pass_err_q, pass_err_d;
  logic                     rep_q, rep_d, rep_ok_q, rep_ok_d;
  logic                     report_q, report_d;
  logic                     last_ok_q, last_ok_d;
  logic [PASS_W-1:0]        pass_cnt_q, pass_cnt_d;
  logic [1:0]               state_q, state_d;
  // clear is a one-cycle reset of everything, including in-flight samples
  assign srst = rst_i | bus.clear;
  always_comb begin
    s1_d = '{v: bus.sample_valid, pd: bus.pass_done, addr: bus.sample_addr,
             exp_a: bus.exp_a, exp_b: bus.exp_b, got_a: bus.got_a, got_b: bus.got_b};
    s2_d = '{v: s1_q.v, pd: s1_q.pd, mis_a: s1_q.exp_a != s1_q.got_a, mis_b: s1_q.exp_b != s1_q.got_b,
             addr: s1_q.addr, got: {s1_q.got_b, s1_q.got_a}};
    mis = s2_q.v & (s2_q.mis_a | s2_q.mis_b);
    cap = mis & ~fv_q;
    err_d = (mis && err_q != '1) ? err_q + 1'b1 : err_q;
    fv_d = fv_q | mis;
    fa_d = cap ? s2_q.addr : fa_q;
    fc_d = cap ? {s2_q.mis_b, s2_q.mis_a} : fc_q;
    fg_d = cap ? s2_q.got : fg_q;
    // the sample riding with pass_done closes the pass; its verdict is taken here and
    // published two cycles later, so back-to-back pass_done each keep their own verdict
    rep_d = s2_q.pd;
    rep_ok_d = ~(pass_err_q | mis);
    pass_err_d = s2_q.pd ? 1'b0 : pass_err_q | mis;
    report_d = rep_q;
    last_ok_d = rep_q ? rep_ok_q : last_ok_q;
    pass_cnt_d = pass_cnt_q + PASS_W'(rep_q);
    state_d = (state_q == ST_IDLE) ? ((bus.sample_valid | bus.pass_done) ? ST_RUN : ST_IDLE) :
              s2_q.pd              ? ST_DRAIN :
              (state_q == ST_DRAIN)  ? ST_REPORT :
              (state_q == ST_REPORT) ? ST_RUN : state_q;
  end
  always_ff @(posedge clk_i) begin
    if (srst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      err_q      <= '0;
      fv_q       <= 1'b0;
      fa_q       <= '0;
      fc_q       <= '0;
      fg_q       <= '0;
      pass_err_q <= 1'b0;
      rep_q      <= 1'b0;
      rep_ok_q   <= 1'b0;
      report_q   <= 1'b0;
      last_ok_q  <= 1'b0;
      pass_cnt_q <= '0;
      state_q    <= ST_IDLE;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      err_q      <= err_d;
      fv_q       <= fv_d;
      fa_q       <= fa_d;
      fc_q       <= fc_d;
      fg_q       <= fg_d;
      pass_err_q <= pass_err_d;
      rep_q      <= rep_d;
      rep_ok_q   <= rep_ok_d;
      report_q   <= report_d;
      last_ok_q  <= last_ok_d;
      pass_cnt_q <= pass_cnt_d;
      state_q    <= state_d;
    end
  end
  pulse_stretch #(.CLOCKS(STRETCH)) u_stretch (
    .clk_i  (clk_i),
    .rst_i  (srst),
    .trig_i (mis),
    .out_o  (bus.led_fail)
  );
  assign bus.err_count       = err_q;
  assign bus.first_err_valid = fv_q;
  assign bus.first_err_addr  = fa_q;
  assign bus.first_err_chip  = fc_q;
  assign bus.first_err_got   = fg_q;
  assign bus.pass_count      = pass_cnt_q;
  assign bus.pass_report     = report_q;
  assign bus.last_pass_ok    = last_ok_q;
  assign bus.led_ok          = (pass_cnt_q != '0) && last_ok_q;
  assign bus.state           = state_q;
endmodule
